// File: rtl/cpu_core_datapath.sv
// Single-cycle CPU datapath: fetch from internal instruction RAM, decode, ALU,
// branch resolution and word-addressed data RAM; the register file lives outside.
module cpu_core_datapath #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_we,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [3:0]  rd,
  output logic [31:0] rd_value,
  output logic        reg_write_en,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        halt
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_ADDI  = 4'h6,
    OP_SLT   = 4'h7,
    OP_LOAD  = 4'h8,
    OP_STORE = 4'h9,
    OP_BEQ   = 4'hA,
    OP_BNE   = 4'hB,
    OP_JMP   = 4'hC,
    OP_JAL   = 4'hD,
    OP_LUI   = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;

  opcode_e            opcode;
  logic [15:0]        imm;
  logic [31:0]        sext_imm;
  logic [31:0]        eff_addr;
  logic [31:0]        dmem_rdata;
  logic [31:0]        alu_res;
  logic               wr_raw;
  logic               br_taken;
  logic               dmem_we;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic               unused_addr_bits;

  assign instruction = imem[pc_q[IA-1:0]];
  assign pc          = pc_q;
  assign opcode      = opcode_e'(instruction[31:28]);
  assign rd          = instruction[27:24];
  assign rs1         = instruction[23:20];
  assign rs2         = instruction[19:16];
  assign imm         = instruction[15:0];
  assign sext_imm    = {{16{imm[15]}}, imm};
  assign eff_addr    = rs1_val + sext_imm;
  assign dmem_rdata  = dmem[eff_addr[DA-1:0]];
  assign a_s         = rs1_val;
  assign b_s         = rs2_val;

  // Address bits above the memory index wrap silently.
  assign unused_addr_bits = ^{imem_addr[31:IA], eff_addr[31:DA]};

  always_comb begin
    alu_res  = 32'd0;
    wr_raw   = 1'b0;
    br_taken = 1'b0;
    unique case (opcode)
      OP_ADD:   begin alu_res = rs1_val + rs2_val;               wr_raw = 1'b1; end
      OP_SUB:   begin alu_res = rs1_val - rs2_val;               wr_raw = 1'b1; end
      OP_AND:   begin alu_res = rs1_val & rs2_val;               wr_raw = 1'b1; end
      OP_OR:    begin alu_res = rs1_val | rs2_val;               wr_raw = 1'b1; end
      OP_XOR:   begin alu_res = rs1_val ^ rs2_val;               wr_raw = 1'b1; end
      OP_ADDI:  begin alu_res = eff_addr;                        wr_raw = 1'b1; end
      OP_SLT:   begin alu_res = {31'd0, (a_s < b_s)};            wr_raw = 1'b1; end
      OP_LOAD:  begin alu_res = dmem_rdata;                      wr_raw = 1'b1; end
      OP_BEQ:   br_taken = (rs1_val == rs2_val);
      OP_BNE:   br_taken = (rs1_val != rs2_val);
      OP_JMP:   br_taken = 1'b1;
      OP_JAL:   begin alu_res = pc_q + 32'd1; wr_raw = 1'b1; br_taken = 1'b1; end
      OP_LUI:   begin alu_res = {imm, 16'd0};                    wr_raw = 1'b1; end
      default:  ;
    endcase
  end

  // A HALT in flight freezes the PC on the same edge that sets the sticky flag.
  always_comb begin
    halt         = halted_q | (opcode == OP_HALT);
    reg_write_en = wr_raw & ~halt;
    rd_value     = reg_write_en ? alu_res : 32'd0;
    dmem_we      = (opcode == OP_STORE) & ~halted_q;
    halted_d     = halt;
    if (halt)
      pc_d = pc_q;
    else if (br_taken)
      pc_d = {16'd0, imm};
    else
      pc_d = pc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Memory contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (imem_we)
      imem[imem_addr[IA-1:0]] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (dmem_we)
      dmem[eff_addr[DA-1:0]] <= rs2_val;
  end

endmodule

// File: tb/tb_cpu_core_datapath.sv
// Directed bench for cpu_core_datapath: single-instruction vector table applied
// from PC 0 under reset, then multi-cycle programs against a model register file.
module tb_cpu_core_datapath;

  logic        clk;
  logic        reset;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [3:0]  rs1, rs2, rd;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] rd_value;
  logic        reg_write_en;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        halt;

  logic        use_model;
  logic [31:0] tb_a, tb_b;
  logic [31:0] regs [16];

  int checks;
  int errors;

  assign rs1_val = use_model ? regs[rs1] : tb_a;
  assign rs2_val = use_model ? regs[rs2] : tb_b;

  cpu_core_datapath #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .rd           (rd),
    .rd_value     (rd_value),
    .reg_write_en (reg_write_en),
    .pc           (pc),
    .instruction  (instruction),
    .halt         (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        we;
    logic [31:0] val;
    logic        hlt;
    logic [31:0] pc_nx;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    imem_we    = 1'b1;
    imem_addr  = addr;
    imem_wdata = data;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  // One clock with the model register file committing the DUT's write.
  task automatic step();
    logic        w;
    logic [3:0]  r;
    logic [31:0] v;
    w = reg_write_en;
    r = rd;
    v = rd_value;
    @(posedge clk);
    if (w && r != 4'd0) regs[r] = v;
    #1;
  endtask

  task automatic clear_regs();
    for (int k = 0; k < 16; k++) regs[k] = 32'd0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = 32'd0;
    imem_wdata = 32'd0;
    use_model  = 1'b0;
    tb_a       = 32'd0;
    tb_b       = 32'd0;
    clear_regs();

    vecs[0]  = '{32'h13120000, 32'd3,          32'd5,          1'b1, 32'd8,          1'b0, 32'd1};
    vecs[1]  = '{32'h23120000, 32'd3,          32'd5,          1'b1, 32'hFFFFFFFE,   1'b0, 32'd1};
    vecs[2]  = '{32'h33120000, 32'hF0F0F0F0,   32'hFF00FF00,   1'b1, 32'hF000F000,   1'b0, 32'd1};
    vecs[3]  = '{32'h43120000, 32'hF0F0F0F0,   32'hFF00FF00,   1'b1, 32'hFFF0FFF0,   1'b0, 32'd1};
    vecs[4]  = '{32'h53120000, 32'hF0F0F0F0,   32'hFF00FF00,   1'b1, 32'h0FF00FF0,   1'b0, 32'd1};
    vecs[5]  = '{32'h6310FFFF, 32'd0,          32'd0,          1'b1, 32'hFFFFFFFF,   1'b0, 32'd1};
    vecs[6]  = '{32'h73120000, 32'hFFFFFFFF,   32'd1,          1'b1, 32'd1,          1'b0, 32'd1};
    vecs[7]  = '{32'h73120000, 32'd1,          32'hFFFFFFFF,   1'b1, 32'd0,          1'b0, 32'd1};
    vecs[8]  = '{32'hE3001234, 32'd0,          32'd0,          1'b1, 32'h12340000,   1'b0, 32'd1};
    vecs[9]  = '{32'hA0120006, 32'd7,          32'd7,          1'b0, 32'd0,          1'b0, 32'd6};
    vecs[10] = '{32'hB0120006, 32'd7,          32'd7,          1'b0, 32'd0,          1'b0, 32'd1};
    vecs[11] = '{32'hF0000000, 32'd0,          32'd0,          1'b0, 32'd0,          1'b1, 32'd0};
    vecs[12] = '{32'hB0120006, 32'd1,          32'd2,          1'b0, 32'd0,          1'b0, 32'd6};
    vecs[13] = '{32'hC0000020, 32'd0,          32'd0,          1'b0, 32'd0,          1'b0, 32'h20};
    vecs[14] = '{32'hD5000009, 32'd0,          32'd0,          1'b1, 32'd1,          1'b0, 32'd9};
    vecs[15] = '{32'h00000000, 32'd0,          32'd0,          1'b0, 32'd0,          1'b0, 32'd1};

    // Single instructions at PC 0: decode checked while in reset, next PC after one edge.
    for (int i = 0; i < 16; i++) begin
      load_word(32'd0, vecs[i].instr);
      tb_a = vecs[i].a;
      tb_b = vecs[i].b;
      #1;
      chk($sformatf("v%0d_pc_rst", i), pc, 32'd0);
      chk($sformatf("v%0d_we", i), {31'd0, reg_write_en}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_val", i), rd_value, vecs[i].val);
      chk($sformatf("v%0d_halt", i), {31'd0, halt}, {31'd0, vecs[i].hlt});
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc_next", i), pc, vecs[i].pc_nx);
      reset = 1'b0;
      #1;
    end

    // Program A: arithmetic chain ending in HALT, then sticky halt behaviour.
    load_word(32'd0, 32'h61000005);
    load_word(32'd1, 32'h62000007);
    load_word(32'd2, 32'h13120000);
    load_word(32'd3, 32'hF0000000);
    use_model = 1'b1;
    clear_regs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("a_halt_clear", {31'd0, halt}, 32'd0);
    step(); step(); step();
    chk("a_r3", regs[3], 32'd12);
    chk("a_pc3", pc, 32'd3);
    chk("a_halt", {31'd0, halt}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("a_hold_pc%0d", c), pc, 32'd3);
      chk($sformatf("a_hold_we%0d", c), {31'd0, reg_write_en}, 32'd0);
    end
    load_word(32'd3, 32'h00000000);
    chk("a_sticky_halt", {31'd0, halt}, 32'd1);
    step();
    chk("a_sticky_pc", pc, 32'd3);

    // Program B: memory, branches, JAL, wrap, asynchronous mid-program reset.
    reset = 1'b0;
    #1;
    chk("b_rst_pc", pc, 32'd0);
    chk("b_rst_halt", {31'd0, halt}, 32'd0);
    load_word(32'd0, 32'h90020010);
    load_word(32'd1, 32'h84000010);
    load_word(32'd2, 32'hA0110008);
    load_word(32'd8, 32'hB0000007);
    load_word(32'd9, 32'hC0000004);
    load_word(32'd4, 32'hD5000005);
    load_word(32'd5, 32'h90020103);
    load_word(32'd6, 32'h86000003);
    load_word(32'd7, 32'hF0000000);
    clear_regs();
    regs[2] = 32'hDEADBEEF;
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("b_load_pc", pc, 32'd1);
    chk("b_load_val", rd_value, 32'hDEADBEEF);
    chk("b_load_we", {31'd0, reg_write_en}, 32'd1);
    chk("b_load_rd", {28'd0, rd}, 32'd4);
    step();
    chk("b_r4", regs[4], 32'hDEADBEEF);
    chk("b_beq_src_pc", pc, 32'd2);
    step();
    chk("b_beq_pc", pc, 32'd8);
    step();
    chk("b_bne_fall_pc", pc, 32'd9);
    step();
    chk("b_jmp_pc", pc, 32'd4);
    chk("b_jal_val", rd_value, 32'd5);
    chk("b_jal_we", {31'd0, reg_write_en}, 32'd1);
    step();
    chk("b_jal_pc", pc, 32'd5);
    chk("b_r5", regs[5], 32'd5);
    #3;
    reset = 1'b0;
    #1;
    chk("b_async_pc", pc, 32'd0);
    chk("b_async_halt", {31'd0, halt}, 32'd0);
    regs[4] = 32'd0;
    regs[5] = 32'd0;
    regs[6] = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("b_rerun_pc5", pc, 32'd5);
    chk("b_store_we", {31'd0, reg_write_en}, 32'd0);
    chk("b_rerun_halt", {31'd0, halt}, 32'd0);
    step();
    chk("b_wrap_val", rd_value, 32'hDEADBEEF);
    step();
    chk("b_r6", regs[6], 32'hDEADBEEF);
    chk("b_end_pc", pc, 32'd7);
    chk("b_end_halt", {31'd0, halt}, 32'd1);
    step();
    chk("b_end_hold_pc", pc, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
